im_loader: RTL
==============

Name: im_loader

Overview:
- Parametrised successor to the fixed-content instruction memory of the 8-bit CPU.
- Same fetch interface: `addr` in, instruction word out. Content is no longer hard-coded: it is cleared, then streamed in through a valid/ready loader port.
- Only after loading does the block release the CPU through `run`.
- Fetch read is optionally registered, for timing closure on larger depths.

Parameters:
- IW, 13, instruction width in bits (5-bit opcode + 8-bit operand by default).
- AW, 8, address width; memory depth is 2**AW words.
- REG_OUT, 0, 0 = combinational fetch read; 1 = registered fetch read (one-cycle latency).
- NOP_WORD, 13'h0000, fill value written during clear and driven on `dout` while not running.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  AW  CPU fetch address (PC).
- dout  out  IW  fetched instruction word.
- ld_start  in  1  request a reload (clear + load); sampled in RUN only.
- ld_valid  in  1  loader word valid.
- ld_data  in  IW  loader word.
- ld_last  in  1  marks the final word of the program; qualified by `ld_valid & ld_ready`.
- ld_ready  out  1  block can accept a loader word this cycle.
- ld_count  out  AW+1  number of words accepted in the current/last load.
- run  out  1  program loaded; CPU may fetch and execute.
- ovf  out  1  sticky: load filled all 2**AW words without `ld_last`.

Behaviour:
- One clock domain. `rst` is synchronous, active-high and has priority over every other input.
- Reset values:
  - state = CLEAR, clear pointer = 0, write pointer = 0.
  - `ld_count` = 0, `run` = 0, `ovf` = 0, `ld_ready` = 0.
  - `dout` = NOP_WORD; when REG_OUT=1 the output register also resets to NOP_WORD.
- CLEAR state:
  - Writes NOP_WORD to memory[clear pointer] each cycle; pointer increments by 1.
  - Takes exactly 2**AW cycles, then goes to LOAD.
  - `ld_ready` = 0 throughout.
- LOAD state:
  - `ld_ready` = 1.
  - On `ld_valid & ld_ready`: memory[write pointer] <= `ld_data`; write pointer += 1; `ld_count` += 1.
  - `ld_valid` without `ld_ready` is ignored; no word is lost or duplicated.
  - Transfer with `ld_last`=1 goes to RUN on the next edge.
  - Transfer at write pointer = 2**AW-1 with `ld_last`=0 goes to RUN and sets `ovf`.
  - Transfer at the last address with `ld_last`=1 goes to RUN with `ovf` unchanged.
  - `ld_last` without `ld_valid` has no effect.
- RUN state:
  - `run` = 1, `ld_ready` = 0; memory is read-only from the loader side.
  - `ld_start`=1 goes to CLEAR. Clear pointer, write pointer and `ld_count` reset to 0; `run` drops on the next cycle.
  - `ovf` is cleared only by reset or by entering CLEAR.
- `ld_start` in CLEAR or LOAD is ignored; an in-progress load is never aborted except by `rst`.
- Fetch read, REG_OUT=0:
  - `dout` = memory[`addr`] combinationally when `run`=1.
  - `dout` = NOP_WORD otherwise.
- Fetch read, REG_OUT=1:
  - `dout` register <= (`run` ? memory[`addr`] : NOP_WORD) each edge.
  - Data for `addr` presented in cycle n appears in cycle n+1.
- Address width: `addr` uses all AW bits, with no wrap beyond depth. The write pointer is AW bits and its wrap is prevented by the overflow rule.
- No read-during-write hazard: fetch and load never overlap, because reads return NOP_WORD outside RUN.
- Reset in mid-LOAD or mid-CLEAR restarts from CLEAR; all memory content is re-filled.

Test Plan:
- Reset then idle 256 cycles (AW=8) -> `ld_ready` rises in cycle 257 after reset release. `dout`=0 and `run`=0 throughout.
- Load 19 words (opcode/operand pairs, e.g. {5'b01000,8'd0} ... {5'b01111,8'd18}) with `ld_last` on word 19 -> `ld_count`=19, `run`=1, `ovf`=0. Reading addr 0..18 returns the loaded words; addr 19..255 return NOP_WORD.
- Same load with random `ld_valid` gaps, and `ld_valid` held high while `ld_ready`=0 during CLEAR -> identical memory image, `ld_count`=19, no duplicate writes.
- Stream 256 words with `ld_last`=0 -> `run`=1 after word 256, `ovf`=1, `ld_count`=256. Then assert `ld_start` -> `run`=0, `ovf`=0, CLEAR lasts 256 cycles.
- REG_OUT=1: load 4 words, then drive addr 0,1,2,3 on consecutive cycles -> `dout` shows word0..word3 one cycle later each. `dout`=NOP_WORD in the first RUN cycle.
- Assert `rst` after 10 accepted words in LOAD -> next cycle `ld_count`=0, `ld_ready`=0. After reload of 2 words, addr 2..9 read NOP_WORD (old content cleared).

Source files
------------

// File: rtl/im_loader.sv
// Loadable instruction memory: cleared, streamed in over valid/ready, then fetched by the CPU.
// Fetch latency 0 (REG_OUT=0) or 1 cycle (REG_OUT=1); ld_ready is high only in LOAD, words are held off otherwise.
module im_loader #(
    parameter int              IW       = 13,
    parameter int              AW       = 8,
    parameter int              REG_OUT  = 0,
    parameter logic [IW-1:0]   NOP_WORD = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    output logic [IW-1:0] dout,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW:0]   ld_count,
    output logic          run,
    output logic          ovf
);

    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_TOP = '1;

    logic [1:0]    state;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] wr_ptr;
    logic          xfer;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [IW-1:0] mem_wdata;
    logic [IW-1:0] rd_word;
    logic [IW-1:0] mem [0:DEPTH-1];

    assign ld_ready = (state == S_LOAD);
    assign run      = (state == S_RUN);
    assign xfer     = ld_valid & ld_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_ptr  <= '0;
            wr_ptr   <= '0;
            ld_count <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + PTR_ONE;
                    if (clr_ptr == PTR_TOP) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        wr_ptr   <= wr_ptr + PTR_ONE;
                        ld_count <= ld_count + CNT_ONE;
                        // Last word wins over overflow: a full program ending exactly at the top is not an overflow.
                        if (ld_last) begin
                            state <= S_RUN;
                        end else if (wr_ptr == PTR_TOP) begin
                            state <= S_RUN;
                            ovf   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (ld_start) begin
                        state    <= S_CLEAR;
                        clr_ptr  <= '0;
                        wr_ptr   <= '0;
                        ld_count <= '0;
                        ovf      <= 1'b0;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // Single write port shared by the clear sweep and the loader; the two never coincide.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr;
        mem_wdata = ld_data;
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = NOP_WORD;
            end else if (xfer) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word = mem[addr];

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [IW-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= NOP_WORD;
                end else begin
                    dout_q <= run ? rd_word : NOP_WORD;
                end
            end
            assign dout = dout_q;
        end else begin : g_comb_out
            assign dout = run ? rd_word : NOP_WORD;
        end
    endgenerate

endmodule
